// File: rtl/adc_scan_avg_if.sv
// Bundle of the ADC-side handshake (address, CS_N, data) and the tagged result stream.
// "master" is the scanner's view; "slave" is the view of whatever surrounds it.
interface adc_scan_avg_if;
    logic        enable;
    logic        adc_cs_n;
    logic [11:0] adc_data;
    logic [2:0]  addr;
    logic        res_valid;
    logic [2:0]  res_ch;
    logic [11:0] res_data;

    modport master (
        input  enable,
        input  adc_cs_n,
        input  adc_data,
        output addr,
        output res_valid,
        output res_ch,
        output res_data
    );

    modport slave (
        output enable,
        output adc_cs_n,
        output adc_data,
        input  addr,
        input  res_valid,
        input  res_ch,
        input  res_data
    );
endinterface

// File: rtl/adc_scan_avg.sv
// Round-robin channel scanner for the serial ADC: drives the channel address, captures each
// frame's result on the CS_N rise and emits one truncated 2^AVG_LOG2-sample average per channel.
module adc_scan_avg #(
    parameter int NUM_CH   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic           clock,
    input  logic           rst_n,
    adc_scan_avg_if.master bus
);

    localparam int              ACC_W      = 12 + AVG_LOG2;
    localparam int              SW         = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SW-1:0]   LAST_SWEEP = SW'((1 << AVG_LOG2) - 1);
    localparam logic [2:0]      LAST_CH    = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic              cs_q;
    logic              edge_q;
    logic [2:0]        addr_q, addr_d;
    logic [2:0]        prev_ch_q, prev_ch_d;
    logic [SW-1:0]     sweep_q, sweep_d;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic              res_valid_q, res_valid_d;
    logic [2:0]        res_ch_q, res_ch_d;
    logic [11:0]       res_data_q, res_data_d;

    logic              cs_rise;
    logic              capture;
    logic [2:0]        next_addr;
    logic [ACC_W-1:0]  acc_sel;
    logic [ACC_W-1:0]  sum;
    logic              last_sweep;

    assign cs_rise    = ~cs_q & bus.adc_cs_n;
    assign capture    = edge_q;
    assign next_addr  = (addr_q == LAST_CH) ? 3'd0 : addr_q + 3'd1;
    assign last_sweep = (sweep_q == LAST_SWEEP);

    // Accumulator of the channel whose data arrives now; a loop avoids indexing past NUM_CH.
    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (prev_ch_q == 3'(i)) begin
                acc_sel = acc_q[i];
            end
        end
    end

    assign sum = acc_sel + ACC_W'(bus.adc_data);

    // NOTE: every variable gets its default at the top so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        prev_ch_d   = prev_ch_q;
        sweep_d     = sweep_q;
        acc_d       = acc_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;

        if (!bus.enable) begin
            // Dropping enable abandons the scan, including any capture in this same cycle.
            state_d = IDLE;
            addr_d  = 3'd0;
            sweep_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    addr_d  = 3'd0;
                    state_d = PRIME;
                end
                PRIME: begin
                    if (capture) begin
                        // This frame's data belongs to a channel chosen before the scan started.
                        prev_ch_d = 3'd0;
                        addr_d    = next_addr;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (capture) begin
                        prev_ch_d = addr_q;
                        addr_d    = next_addr;
                        if (prev_ch_q == LAST_CH) begin
                            sweep_d = last_sweep ? '0 : sweep_q + SW'(1);
                        end
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (prev_ch_q == 3'(i)) begin
                                acc_d[i] = last_sweep ? '0 : sum;
                            end
                        end
                        if (last_sweep) begin
                            res_valid_d = 1'b1;
                            res_ch_d    = prev_ch_q;
                            res_data_d  = 12'(sum >> AVG_LOG2);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cs_q        <= 1'b0;
            edge_q      <= 1'b0;
            addr_q      <= 3'd0;
            prev_ch_q   <= 3'd0;
            sweep_q     <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= 3'd0;
            res_data_q  <= 12'd0;
        end else begin
            state_q     <= state_d;
            cs_q        <= bus.adc_cs_n;
            edge_q      <= cs_rise;
            addr_q      <= addr_d;
            prev_ch_q   <= prev_ch_d;
            sweep_q     <= sweep_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
        end
    end

    // NOTE: the accumulator array is reset because a restarted scan must average only fresh
    // samples; it is small register storage, not a RAM macro.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign bus.addr      = addr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_data  = res_data_q;

endmodule
